// File: rtl/prog_if_pkg.sv
// Shared definitions for the program-load interface: default geometry,
// phase lengths and the replay FSM state encoding.
package prog_if_pkg;

    localparam int DEPTH_DEF      = 16;
    localparam int INSTR_W_DEF    = 5;
    localparam int SETUP_CYC_DEF  = 2;
    localparam int STROBE_CYC_DEF = 2;
    localparam int HOLD_CYC_DEF   = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_FIN    = 3'd4
    } state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/prog_table.sv
// DEPTH x INSTR_W program table: synchronous clear, one write port and an
// asynchronous read port.
module prog_table
    import prog_if_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEF,
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int AW      = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               clear_n_i,
    input  logic               wr_en_i,
    input  logic [AW-1:0]      wr_addr_i,
    input  logic [INSTR_W-1:0] wr_data_i,
    input  logic [AW-1:0]      rd_addr_i,
    output logic [INSTR_W-1:0] rd_data_o
);

    logic [INSTR_W-1:0] mem_q [DEPTH];

    // Table storage: cleared by reset, written one entry per cycle.
    always_ff @(posedge clk) begin
        if (!clear_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/prog_feeder.sv
// Replays the program table onto the instruc/enable load interface as
// setup / strobe / hold sequences, one entry at a time.
module prog_feeder
    import prog_if_pkg::*;
#(
    parameter int DEPTH      = DEPTH_DEF,
    parameter int INSTR_W    = INSTR_W_DEF,
    parameter int SETUP_CYC  = SETUP_CYC_DEF,
    parameter int STROBE_CYC = STROBE_CYC_DEF,
    parameter int HOLD_CYC   = HOLD_CYC_DEF
) (
    input  logic                       clk,
    input  logic                       clear_n,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [INSTR_W-1:0]         wr_data,
    input  logic                       start,
    input  logic [$clog2(DEPTH):0]     count,
    output logic [INSTR_W-1:0]         instruc,
    output logic                       enable,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH)-1:0]   idx
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = $clog2(max3(SETUP_CYC, STROBE_CYC, HOLD_CYC) + 1);

    localparam logic [PW-1:0] SETUP_LAST  = PW'(SETUP_CYC - 1);
    localparam logic [PW-1:0] STROBE_LAST = PW'(STROBE_CYC - 1);
    localparam logic [PW-1:0] HOLD_LAST   = PW'(HOLD_CYC - 1);

    state_e             state_q,   state_d;
    logic [PW-1:0]      phase_q,   phase_d;
    logic [AW-1:0]      idx_q,     idx_d;
    logic [AW-1:0]      last_q,    last_d;
    logic [INSTR_W-1:0] instruc_q, instruc_d;
    logic               enable_q,  enable_d;
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;

    logic               tbl_wr_s;
    logic [AW-1:0]      rd_addr_s;
    logic [INSTR_W-1:0] rd_data_s;
    logic [INSTR_W-1:0] first_s;

    assign tbl_wr_s  = wr_en && (state_q == ST_IDLE);
    assign rd_addr_s = (state_q == ST_HOLD) ? (idx_q + AW'(1)) : '0;
    // A write to entry 0 in the start cycle must be seen by the replay.
    assign first_s   = (tbl_wr_s && (wr_addr == '0)) ? wr_data : rd_data_s;

    prog_table #(
        .DEPTH   (DEPTH),
        .INSTR_W (INSTR_W),
        .AW      (AW)
    ) u_table (
        .clk       (clk),
        .clear_n_i (clear_n),
        .wr_en_i   (tbl_wr_s),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .rd_addr_i (rd_addr_s),
        .rd_data_o (rd_data_s)
    );

    // Next-state, phase counter and registered-output next values.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        idx_d     = idx_q;
        last_d    = last_q;
        instruc_d = instruc_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (count == '0) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d   = ST_SETUP;
                        idx_d     = '0;
                        instruc_d = first_s;
                        last_d    = (count > CW'(DEPTH)) ? AW'(DEPTH - 1)
                                                         : AW'(count - CW'(1));
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (phase_q == '0) begin
                    state_d = ST_STROBE;
                end else begin
                    state_d = ST_SETUP;
                end
            end
            ST_STROBE: begin
                if (phase_q == '0) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_STROBE;
                end
            end
            ST_HOLD: begin
                if (phase_q != '0) begin
                    state_d = ST_HOLD;
                end else if (idx_q == last_q) begin
                    state_d = ST_FIN;
                end else begin
                    state_d   = ST_SETUP;
                    idx_d     = idx_q + AW'(1);
                    instruc_d = rd_data_s;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Phase counter reloads with (length-1) on every state change.
        if (state_d != state_q) begin
            case (state_d)
                ST_SETUP:  phase_d = SETUP_LAST;
                ST_STROBE: phase_d = STROBE_LAST;
                ST_HOLD:   phase_d = HOLD_LAST;
                default:   phase_d = '0;
            endcase
        end else if (phase_q != '0) begin
            phase_d = phase_q - PW'(1);
        end else begin
            phase_d = phase_q;
        end

        if (state_d == ST_FIN) begin
            instruc_d = '0;
        end else begin
            instruc_d = instruc_d;
        end

        enable_d = (state_d == ST_STROBE);
        busy_d   = (state_d == ST_SETUP) || (state_d == ST_STROBE) ||
                   (state_d == ST_HOLD);
        done_d   = (state_d == ST_FIN);
    end

    // State, phase and output registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (!clear_n) begin
            state_q   <= ST_IDLE;
            phase_q   <= '0;
            idx_q     <= '0;
            last_q    <= '0;
            instruc_q <= '0;
            enable_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
            instruc_q <= instruc_d;
            enable_q  <= enable_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign instruc = instruc_q;
    assign enable  = enable_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign idx     = idx_q;

endmodule

// File: tb/tb_prog_feeder.sv
// Randomized self-checking bench for prog_feeder against a per-cycle
// timeline model derived from the table contents and phase lengths.
module tb_prog_feeder;

    localparam int DEPTH = 16;
    localparam int IW    = 5;
    localparam int S     = 2;
    localparam int T     = 2;
    localparam int H     = 2;
    localparam int P     = S + T + H;

    logic          clk = 1'b0;
    logic          clear_n;
    logic          wr_en;
    logic [3:0]    wr_addr;
    logic [IW-1:0] wr_data;
    logic          start;
    logic [4:0]    count;
    logic [IW-1:0] instruc;
    logic          enable;
    logic          busy;
    logic          done;
    logic [3:0]    idx;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [IW-1:0] mem_m [DEPTH];
    logic [IW-1:0] prev_instr;
    logic          prev_en;

    always #5 clk = ~clk;

    prog_feeder dut (
        .clk     (clk),
        .clear_n (clear_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .start   (start),
        .count   (count),
        .instruc (instruc),
        .enable  (enable),
        .busy    (busy),
        .done    (done),
        .idx     (idx)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, ".instruc"}, instruc, 0);
        check_eq({tag, ".enable"},  enable,  0);
        check_eq({tag, ".busy"},    busy,    0);
        check_eq({tag, ".done"},    done,    0);
    endtask

    task automatic do_write(input logic [3:0] a, input logic [IW-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        mem_m[a] = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pulse_reset();
        clear_n = 1'b0;
        tick();
        clear_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    endtask

    // Expected output in cycle c after the start edge: entry (c-1)/P,
    // strobe occupies offsets S..S+T-1, then a single done cycle.
    task automatic run_replay(input int cnt, input bit noise, input int abort_at,
                              input bit ws, input logic [3:0] wa,
                              input logic [IW-1:0] wd);
        int n, total, e, off;
        logic          exp_en;
        logic [IW-1:0] exp_in;
        start = 1'b1;
        count = 5'(cnt);
        if (ws) begin
            wr_en   = 1'b1;
            wr_addr = wa;
            wr_data = wd;
            mem_m[wa] = wd;
        end
        tick();
        start = 1'b0;
        wr_en = 1'b0;
        n     = (cnt > DEPTH) ? DEPTH : cnt;
        total = n * P + 1;
        prev_en    = 1'b0;
        prev_instr = '0;
        for (int c = 1; c <= total; c++) begin
            if (c <= n * P) begin
                e      = (c - 1) / P;
                off    = (c - 1) % P;
                exp_en = (off >= S) && (off < S + T);
                exp_in = mem_m[e];
                check_eq("run.instruc", instruc, exp_in);
                check_eq("run.enable",  enable,  exp_en);
                check_eq("run.busy",    busy,    1);
                check_eq("run.done",    done,    0);
                check_eq("run.idx",     idx,     e);
            end else begin
                check_eq("fin.instruc", instruc, 0);
                check_eq("fin.enable",  enable,  0);
                check_eq("fin.busy",    busy,    0);
                check_eq("fin.done",    done,    1);
            end
            if (enable || (enable != prev_en)) begin
                check_eq("stable", instruc, prev_instr);
            end
            prev_en    = enable;
            prev_instr = instruc;
            if (c == abort_at) begin
                start = 1'b0;
                wr_en = 1'b0;
                pulse_reset();
                check_quiet("abort");
                check_eq("abort.idx", idx, 0);
                for (int k = 0; k < 10; k++) begin
                    tick();
                    check_quiet("after_abort");
                end
                return;
            end
            if (noise && (c <= n * P)) begin
                start   = 1'($urandom_range(0, 1));
                count   = 5'($urandom_range(0, 31));
                wr_en   = 1'($urandom_range(0, 1));
                wr_addr = 4'($urandom_range(0, 15));
                wr_data = 5'($urandom_range(0, 31));
            end else begin
                start = 1'b0;
                wr_en = 1'b0;
            end
            tick();
        end
        check_quiet("post");
    endtask

    task automatic fill_random();
        for (int i = 0; i < DEPTH; i++) begin
            do_write(4'(i), 5'($urandom_range(0, 31)));
        end
    endtask

    initial begin
        clear_n = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        start   = 1'b0;
        count   = '0;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        tick();
        tick();
        clear_n = 1'b1;
        check_quiet("reset");
        check_eq("reset.idx", idx, 0);

        do_write(4'd0, 5'b00000);
        do_write(4'd1, 5'b01101);
        do_write(4'd2, 5'b01000);
        run_replay(3, 1'b0, 0, 1'b0, 4'd0, 5'd0);

        run_replay(0, 1'b0, 0, 1'b0, 4'd0, 5'd0);

        // Abort during the strobe of entry index 1 (cycle 9), then replay.
        run_replay(3, 1'b0, 9, 1'b0, 4'd0, 5'd0);
        run_replay(3, 1'b0, 0, 1'b0, 4'd0, 5'd0);

        fill_random();
        run_replay(20, 1'b0, 0, 1'b0, 4'd0, 5'd0);
        run_replay(16, 1'b1, 0, 1'b0, 4'd0, 5'd0);
        run_replay(16, 1'b0, 0, 1'b0, 4'd0, 5'd0);

        run_replay(4, 1'b0, 0, 1'b1, 4'd0, 5'($urandom_range(0, 31)));
        run_replay(3, 1'b0, 0, 1'b1, 4'd2, 5'($urandom_range(0, 31)));

        for (int r = 0; r < 6; r++) begin
            for (int w = 0; w < 4; w++) begin
                do_write(4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)));
            end
            run_replay($urandom_range(0, 31), 1'($urandom_range(0, 1)), 0,
                       1'b0, 4'd0, 5'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
